rr_decoder_arbiter: RTL and testbench
=====================================

# rr_decoder_arbiter

Round-robin arbiter that shares one 2-to-4 decoder between four requesters. It drives the decoder's select (`sel`, A1:A0) and enable (`en`) and produces the decoded one-hot grant. Grants are held while the owner keeps requesting, capped at `HOLD_MAX` cycles, with one dead cycle between owners. It sits directly in front of the `decoder` block, which it sequences.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles per owner; legal range 1..255.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  4: request vector. Bit i is requester i, level-sensitive, held until the requester is done.
- `sel`  out 2: decoder select {A1,A0}, index of the current or last owner.
- `en`  out 1: decoder enable; 1 only while a grant is active.
- `gnt`  out 4: one-hot grant, equal to decode(`sel`) when `en`=1, else 0000.
- `timeout`  out 1: one-cycle pulse when a grant ended because `HOLD_MAX` was reached.

## Operation
- Internal state:
  - FSM: IDLE, GRANT, GAP.
  - `ptr[1:0]`: last granted index.
  - `cnt[7:0]`: grant-cycle counter.
- All outputs are registered.
- Winner selection: the first asserted `req` bit searching `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4). The previous owner is therefore lowest priority.
- IDLE (`en`=0, `gnt`=0000):
  - If `req`≠0 at the edge: go to GRANT, `sel`←winner, `ptr`←winner, `cnt`←1, `en`←1, `gnt`←one-hot(winner).
  - Otherwise stay in IDLE.
- GRANT:
  - If `req[sel]`=0 at the edge: go to GAP, `en`←0, `gnt`←0000.
  - Else if `cnt`==`HOLD_MAX`: go to GAP, `en`←0, `gnt`←0000, `timeout`←1.
  - Else: stay in GRANT, `cnt`←`cnt`+1.
  - Requests on other bits are ignored while in GRANT.
- GAP (`en`=0, `gnt`=0000, exactly one cycle):
  - If `req`≠0 at the edge: arbitrate exactly as IDLE and go to GRANT.
  - Otherwise go to IDLE.
  - `timeout` clears at this edge.
- `sel` holds its last value whenever `en`=0; it changes only on entry to GRANT.
- `gnt` is always one-hot or zero and always equals `{en&sel==3, en&sel==2, en&sel==1, en&sel==0}`.
- Reset values:
  - state IDLE, `ptr`=3, `cnt`=0.
  - `sel`=00, `en`=0, `gnt`=0000, `timeout`=0.
  - Because `ptr`=3, requester 0 has top priority after reset.
- Reset mid-operation: at the `rst` edge all registers take their reset values regardless of state. The grant drops the following cycle and there is no `timeout` pulse.
- `rst` has priority over all other events.

## Timing
- Request-to-grant latency:
  - `req` sampled at edge k in IDLE gives `gnt` valid from edge k to edge k+1, so it is visible in the cycle after `req` rises.
  - The same 1-cycle latency applies from GAP.
- Release latency: `req[sel]` sampled low at edge k deasserts `gnt` at edge k. The requester sees one cycle of overlap after dropping `req`.
- Grant length:
  - With `req` held continuously, `gnt` is high for exactly `HOLD_MAX` cycles.
  - `HOLD_MAX`=1 gives 1-cycle grants.
- Dead time between consecutive grants is exactly one cycle (GAP). It is never zero, even when the same requester is re-granted.
- `timeout` is high during the GAP cycle that follows a capped grant, and is never high in the same cycle as `en`.
- Simultaneous events:
  - A release and `cnt`==`HOLD_MAX` at the same edge counts as a release: no `timeout`.
  - New requests arriving in GAP are arbitrated at the end of GAP.
- Sole requester: if only the previous owner is requesting, it is re-granted after the one-cycle GAP.

## Test plan
- Reset with `req`=1111 held, `rst`=1 for 3 cycles -> `gnt`=0000, `en`=0, `sel`=00, `timeout`=0 throughout. The first cycle after `rst` falls gives `gnt`=0001, `sel`=00.
- Single requester, `req`=0100 for 3 grant cycles then 0000 -> `gnt`=0100, `sel`=10 for 3 cycles, then 0000 and `en`=0. FSM ends in IDLE, `timeout` stays 0.
- Saturation with `HOLD_MAX`=8 and `req`=1111 held -> grants 0001, 0010, 0100, 1000, 0001, each 8 cycles. Each is separated by one 0000 cycle carrying `timeout`=1.
- Fairness with `req`=1010 held and `HOLD_MAX`=2 -> grant sequence 0010, 0010, 0000, 1000, 1000, 0000, 0010, ..., never starving either requester.
- Reset mid-grant: `gnt`=0100 active, `rst` pulsed 1 cycle with `req`=1111 -> next cycle `gnt`=0000, `sel`=00, no `timeout`. The next grant is 0001.
- Handover: owner 1 drops `req[1]` while `req[0]` rises in the same cycle -> one GAP cycle with `gnt`=0000, then `gnt`=0001, `sel`=00. This holds because the search from `ptr`=1 visits 2, 3, 0.

Source files
------------

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bus between four requesters and the round-robin decoder arbiter.
// Handshake: req[i] is a level held by requester i until it is done; gnt[i] is the
// registered answer, high while requester i owns the decoder. There is no ready/ack.
interface rr_decoder_arbiter_if;
  logic [3:0] req;
  logic [1:0] sel;
  logic       en;
  logic [3:0] gnt;
  logic       timeout;

  modport master (output req, input sel, en, gnt, timeout);
  modport slave  (input req, output sel, en, gnt, timeout);
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sequencing a shared 2-to-4 decoder among four requesters,
// with a per-owner hold cap and one dead cycle between owners.
module rr_decoder_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_decoder_arbiter_if.slave  bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] sel_nxt;
  logic       en_nxt;
  logic [3:0] gnt_nxt;
  logic       timeout_nxt;

  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       at_cap;

  // Nearest asserted request after p wins; p itself is visited last.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign winner    = pick(bus.req, ptr);
  assign any_req   = |bus.req;
  assign owner_req = bus.req[bus.sel];
  assign at_cap    = (cnt == 8'(HOLD_MAX));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd3;
      cnt         <= 8'd0;
      bus.sel     <= 2'd0;
      bus.en      <= 1'b0;
      bus.gnt     <= 4'd0;
      bus.timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      bus.sel     <= sel_nxt;
      bus.en      <= en_nxt;
      bus.gnt     <= gnt_nxt;
      bus.timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (!owner_req || at_cap) state_nxt = GAP;
      GAP:     state_nxt = any_req ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered output values; a release wins over the cap, so no timeout then.
  always_comb begin
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    sel_nxt     = bus.sel;
    en_nxt      = 1'b0;
    gnt_nxt     = 4'd0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (any_req) begin
          ptr_nxt = winner;
          sel_nxt = winner;
          cnt_nxt = 8'd1;
          en_nxt  = 1'b1;
          gnt_nxt = 4'b0001 << winner;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          timeout_nxt = 1'b0;
        end else if (at_cap) begin
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
          en_nxt  = 1'b1;
          gnt_nxt = bus.gnt;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: three instances (HOLD_MAX 8, 2, 1) share one request
// bus; a hand table, corner sequences and random traffic are checked against a model.
module tb_rr_decoder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_w [3];
  logic [1:0] sel_w [3];
  logic [1:0] st_w  [3];
  logic       en_w  [3];
  logic       tmo_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int HOLD = (g == 0) ? 8 : (g == 1) ? 2 : 1;
    rr_decoder_arbiter_if bus ();
    assign bus.req = req;
    rr_decoder_arbiter #(.HOLD_MAX(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (st_w[g])
    );
    assign gnt_w[g] = bus.gnt;
    assign sel_w[g] = bus.sel;
    assign en_w[g]  = bus.en;
    assign tmo_w[g] = bus.timeout;
  end

  // Reference model: who owns the decoder, for how long, and whose turn is next.
  int m_lim   [3] = '{8, 2, 1};
  int m_owner [3];
  int m_last  [3];
  int m_held  [3];
  int m_sel   [3];
  bit m_gap   [3];
  bit m_tmo   [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic r_rst, input logic [3:0] r);
    for (int d = 0; d < 3; d++) begin
      if (r_rst) begin
        m_owner[d] = -1; m_last[d] = 3; m_held[d] = 0;
        m_sel[d] = 0; m_gap[d] = 0; m_tmo[d] = 0;
      end else begin
        m_tmo[d] = 0;
        if (m_owner[d] >= 0) begin
          if (!r[m_owner[d]]) begin
            m_owner[d] = -1; m_gap[d] = 1;
          end else if (m_held[d] == m_lim[d]) begin
            m_owner[d] = -1; m_gap[d] = 1; m_tmo[d] = 1;
          end else begin
            m_held[d]++;
          end
        end else begin
          m_gap[d] = 0;
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last[d] + k) % 4;
            if (r[c] && m_owner[d] < 0) begin
              m_owner[d] = c; m_last[d] = c; m_sel[d] = c; m_held[d] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic model_check();
    for (int d = 0; d < 3; d++) begin
      int st;
      st = (m_owner[d] >= 0) ? 1 : (m_gap[d] ? 2 : 0);
      check($sformatf("model_gnt[%0d]", d), 32'(gnt_w[d]),
            (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0);
      check($sformatf("model_sel[%0d]", d), 32'(sel_w[d]), 32'(m_sel[d]));
      check($sformatf("model_en[%0d]", d), 32'(en_w[d]), 32'(m_owner[d] >= 0));
      check($sformatf("model_timeout[%0d]", d), 32'(tmo_w[d]), 32'(m_tmo[d]));
      check($sformatf("model_state[%0d]", d), 32'(st_w[d]), 32'(st));
    end
  endtask

  // One clock: drive, let the edge pass, advance the model, compare.
  task automatic cycle(input logic r_rst, input logic [3:0] r_req);
    rst = r_rst;
    req = r_req;
    @(posedge clk);
    #1;
    model_step(r_rst, r_req);
    model_check();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       tmo;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(logic r_rst, logic [3:0] r, logic [3:0] g, logic [1:0] s, logic t);
    vec_t v;
    v.rst = r_rst; v.req = r; v.gnt = g; v.sel = s; v.tmo = t;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    req = 4'd0;

    // Reset held with all requests, then requester 0 first.
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    // Single requester 2 for three cycles.
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    // Handover: 1 drops while 0 rises.
    add(0, 4'b0010, 4'b0010, 2'd1, 0);
    add(0, 4'b0010, 4'b0010, 2'd1, 0);
    add(0, 4'b0001, 4'b0000, 2'd1, 0);
    add(0, 4'b0001, 4'b0001, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    // Reset mid-grant.
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].req);
      check($sformatf("tbl_gnt[%0d]", i), 32'(gnt_w[0]), 32'(tbl[i].gnt));
      check($sformatf("tbl_sel[%0d]", i), 32'(sel_w[0]), 32'(tbl[i].sel));
      check($sformatf("tbl_timeout[%0d]", i), 32'(tmo_w[0]), 32'(tbl[i].tmo));
    end

    // Saturation: HOLD_MAX=8 rotates 0,1,2,3,0; HOLD_MAX=1 alternates grant/gap.
    cycle(1, 4'b0000);
    begin
      int t;
      t = 0;
      for (int n = 0; n < 5; n++) begin
        for (int c = 0; c < 8; c++) begin
          cycle(0, 4'b1111);
          check("sat_gnt", 32'(gnt_w[0]), 32'd1 << (n % 4));
          check("sat_timeout_low", 32'(tmo_w[0]), 32'd0);
          if (t < 8)
            check("hold1_gnt", 32'(gnt_w[2]), (t % 2 == 0) ? (32'd1 << (t / 2)) : 32'd0);
          t++;
        end
        cycle(0, 4'b1111);
        check("sat_gap_gnt", 32'(gnt_w[0]), 32'd0);
        check("sat_gap_timeout", 32'(tmo_w[0]), 32'd1);
        t++;
      end
    end

    // Fairness on HOLD_MAX=2 with requesters 1 and 3.
    cycle(1, 4'b0000);
    begin
      logic [3:0] pat [6];
      pat = '{4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
      for (int i = 0; i < 12; i++) begin
        cycle(0, 4'b1010);
        check("fair_gnt", 32'(gnt_w[1]), 32'(pat[i % 6]));
      end
    end

    // Random traffic with sticky requests and rare resets.
    cycle(1, 4'b0000);
    begin
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        cycle(($urandom_range(0, 99) == 0), r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
